wb_btn_gpio: RTL and testbench
==============================

Name: wb_btn_gpio

Overview:
Wishbone classic slave (responder) that gives the CPU master register access to the board buttons and LEDs.
- Buttons: each one is synchronised, debounced and edge-detected, and rising edges raise a maskable interrupt.
- Attachment: sits on the shared Wishbone intercon beside the UART slave; its int_o feeds one bit of the CPU interrupt vector.
- LED outputs: drive led[3:1] once the CPU's LED port is retired.

Parameters:
NBTN, 4, number of button inputs (1-8)
NLED, 3, number of LED outputs (1-8)
DEBOUNCE_CYCLES, 650000, stable cycles required before a button change is accepted (10 ms at 65 MHz); minimum 2

Ports:
wb_clk_i  in  1  Wishbone/system clock (65 MHz)
wb_rst_i  in  1  reset, synchronous, active-high
wb_adr_i  in  32  byte address; only bits [4:2] decoded
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects; only sel[0] is meaningful
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data, valid while ack_o=1
wb_ack_o  out  1  transfer acknowledge
wb_err_o  out  1  error for unmapped address
btn_i  in  NBTN  raw asynchronous button levels
led_o  out  NLED  LED drive
int_o  out  1  interrupt request, level, active-high

Behaviour:
- Reset: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, led_o=0, int_o=0. Synchronisers, debounced state, counters, IRQ_EN and IRQ_PEND are all 0. Reset asserted mid-transfer drops ack/err on the next edge; the transfer is discarded.
- Register map (word offsets; all fields in bits [7:0]; unused bits read 0):
  - 0x00 BTN: RO, debounced state.
  - 0x04 LED: RW.
  - 0x08 IRQ_EN: RW.
  - 0x0C IRQ_PEND: read returns pending; write-1-to-clear.
  - 0x10 RAW: RO, synchronised undebounced state.
  - 0x14-0x1C: unmapped.
- Handshake:
  - req = cyc & stb & !ack_o & !err_o.
  - On req, the next edge asserts ack_o (mapped) or err_o (unmapped) for exactly one cycle, giving one wait state.
  - The master must hold signals until ack/err. Back-to-back transfers therefore take 2 cycles each.
  - wb_dat_o is registered on the same edge as ack and returns 0 when ack is low or on err.
- Writes:
  - Take effect on the edge that raises ack, and only when sel[0]=1. With sel[0]=0 the write is acked but ignored.
  - Writes to RO registers are acked and ignored.
  - Unmapped accesses have no side effects.
- Synchroniser: 2-flop per bit; raw_sync is the output of the second flop.
- Debounce, per bit:
  - If raw_sync == stable, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable<=raw_sync and the counter clears on the same edge.
  - Counter width is clog2(DEBOUNCE_CYCLES).
  - A glitch shorter than DEBOUNCE_CYCLES never changes stable.
- Latency: a clean input change reaches BTN after 2+DEBOUNCE_CYCLES edges.
- Edge detect: rise[i] = stable_next[i] & !stable[i]. A rise sets IRQ_PEND[i] regardless of IRQ_EN; falling edges set nothing.
- Simultaneous W1C and new rise on the same bit in the same cycle: the rise wins and pending stays 1.
- int_o is registered: int_o <= |(IRQ_PEND & IRQ_EN), one cycle after the pend/en update. Enabling a bit whose pend is already set raises int_o.

Decomposition:
- Package gpio_pkg holds:
  - register offset constants (ADR_BTN, ADR_LED, ADR_IRQ_EN, ADR_IRQ_PEND, ADR_RAW);
  - DATA_W=32;
  - the decoded-address width (3).
- Sub-module btn_debounce: one bit, with sync + counter + stable output + rise pulse, parameter DEBOUNCE_CYCLES. It is instantiated NBTN times in a generate loop.
- Top wb_btn_gpio holds the bus FSM and the register file.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then read 0x00, 0x04, 0x08, 0x0C -> each returns 0x00000000. ack is high exactly 1 cycle, 2 cycles after stb.
- Write 0x5 to 0x04 with sel=0x1 -> led_o=3'b101 and readback 0x5. Then write 0x7 with sel=0x0 -> led_o stays 3'b101.
- Drive btn_i[2] 0->1 and hold -> RAW bit2 set after 2 cycles, BTN=0x4 after 6 cycles, IRQ_PEND=0x4, int_o=0 because IRQ_EN=0. Then write IRQ_EN=0x4 -> int_o=1 one cycle later.
- Pulse btn_i[1] high for 3 cycles -> BTN, IRQ_PEND and int_o stay 0.
- With IRQ_PEND[0]=1 and a new btn0 rise landing on the W1C write edge for 0x1 -> pend bit0 remains 1 and int_o remains 1. A later W1C alone clears it and int_o falls.
- Read 0x18 -> err_o for 1 cycle, ack_o=0, dat_o=0, no state change. Assert wb_rst_i while stb is pending -> ack/err low next cycle and all registers are 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants and types for the Wishbone button/LED GPIO block.
package gpio_pkg;

  localparam int unsigned DATA_W = 32;
  // Width of the decoded word address, taken from wb_adr_i[4:2].
  localparam int unsigned ADR_W  = 3;

  localparam logic [ADR_W-1:0] ADR_BTN      = 3'd0;
  localparam logic [ADR_W-1:0] ADR_LED      = 3'd1;
  localparam logic [ADR_W-1:0] ADR_IRQ_EN   = 3'd2;
  localparam logic [ADR_W-1:0] ADR_IRQ_PEND = 3'd3;
  localparam logic [ADR_W-1:0] ADR_RAW      = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StAck,
    StErr
  } bus_state_e;

  // Offsets 0x00..0x10 are backed by registers; 0x14..0x1C are holes.
  function automatic logic adr_mapped(input logic [ADR_W-1:0] adr);
    return adr <= ADR_RAW;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button bit: 2-flop synchroniser, stability counter, debounced level and rise pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic sync,
  output logic stable,
  output logic rise
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             raw_sync;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-stage synchroniser for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      raw_sync <= 1'b0;
    end else begin
      meta     <= raw;
      raw_sync <= meta;
    end
  end

  // Count consecutive cycles of disagreement; accept the new level on the last one.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (raw_sync != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = raw_sync;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Debounced state and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync   = raw_sync;
  assign stable = stable_q;
  // Combinational so the pending bit is set on the same edge that stable rises.
  assign rise   = stable_d & ~stable_q;

endmodule

// File: rtl/wb_btn_gpio.sv
// Wishbone classic slave exposing debounced buttons with maskable rise IRQs and LED outputs.
module wb_btn_gpio
  import gpio_pkg::*;
#(
  parameter int unsigned NBTN            = 4,
  parameter int unsigned NLED            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 650000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  input  logic [NBTN-1:0]   btn_i,
  output logic [NLED-1:0]   led_o,
  output logic              int_o
);

  bus_state_e state_q;
  bus_state_e state_d;

  logic [ADR_W-1:0]  adr;
  logic              mapped;
  logic              req;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dat_q;

  logic [NBTN-1:0]   raw_sync;
  logic [NBTN-1:0]   stable;
  logic [NBTN-1:0]   rise;

  logic [NLED-1:0]   led_q;
  logic [NBTN-1:0]   irq_en_q;
  logic [NBTN-1:0]   irq_pend_q;
  logic [NBTN-1:0]   irq_pend_d;
  logic [NBTN-1:0]   w1c_mask;
  logic              int_q;

  // Address bits outside [4:2], sel[3:1] and high data bits are intentionally ignored.
  logic unused_bus;
  assign unused_bus = ^{wb_adr_i, wb_sel_i, wb_dat_i};

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk   (wb_clk_i),
      .rst   (wb_rst_i),
      .raw   (btn_i[i]),
      .sync  (raw_sync[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  assign adr    = wb_adr_i[4:2];
  assign mapped = adr_mapped(adr);
  // Idle state implies ack_o and err_o are both low.
  assign req    = (state_q == StIdle) && wb_cyc_i && wb_stb_i;
  assign wr_en  = req && mapped && wb_we_i && wb_sel_i[0];

  // Bus FSM next state: one wait state, then a single-cycle ack or err.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = mapped ? StAck : StErr;
        end
      end
      StAck:   state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bus FSM state register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Read mux; unused bits and unmapped offsets read zero.
  always_comb begin
    rd_data = '0;
    case (adr)
      ADR_BTN:      rd_data[NBTN-1:0] = stable;
      ADR_LED:      rd_data[NLED-1:0] = led_q;
      ADR_IRQ_EN:   rd_data[NBTN-1:0] = irq_en_q;
      ADR_IRQ_PEND: rd_data[NBTN-1:0] = irq_pend_q;
      ADR_RAW:      rd_data[NBTN-1:0] = raw_sync;
      default:      rd_data = '0;
    endcase
  end

  // Pending update: W1C clears, then a coincident rise sets the bit back.
  always_comb begin
    w1c_mask = '0;
    if (wr_en && (adr == ADR_IRQ_PEND)) begin
      w1c_mask = wb_dat_i[NBTN-1:0];
    end
    irq_pend_d = (irq_pend_q & ~w1c_mask) | rise;
  end

  // Register file, registered read data and interrupt output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      led_q      <= '0;
      irq_en_q   <= '0;
      irq_pend_q <= '0;
      int_q      <= 1'b0;
      dat_q      <= '0;
    end else begin
      if (wr_en && (adr == ADR_LED)) begin
        led_q <= wb_dat_i[NLED-1:0];
      end
      if (wr_en && (adr == ADR_IRQ_EN)) begin
        irq_en_q <= wb_dat_i[NBTN-1:0];
      end
      irq_pend_q <= irq_pend_d;
      int_q      <= |(irq_pend_q & irq_en_q);
      dat_q      <= (req && mapped) ? rd_data : '0;
    end
  end

  assign wb_ack_o = (state_q == StAck);
  assign wb_err_o = (state_q == StErr);
  assign wb_dat_o = dat_q;
  assign led_o    = led_q;
  assign int_o    = int_q;

endmodule

// File: tb/tb_wb_btn_gpio.sv
// Scoreboard bench for wb_btn_gpio with DEBOUNCE_CYCLES=4.
module tb_wb_btn_gpio;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr_i;
  logic [31:0] dat_i;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic [3:0]  btn;
  logic [2:0]  led;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] dat;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  wb_btn_gpio #(
    .NBTN           (4),
    .NLED           (3),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .wb_adr_i(adr_i),
    .wb_dat_i(dat_i),
    .wb_sel_i(sel_i),
    .wb_we_i (we_i),
    .wb_cyc_i(cyc_i),
    .wb_stb_i(stb_i),
    .wb_dat_o(dat_o),
    .wb_ack_o(ack_o),
    .wb_err_o(err_o),
    .btn_i   (btn),
    .led_o   (led),
    .int_o   (irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // One classic transfer; called #1 after an edge, returns #1 after an edge.
  task automatic bus(input string name, input logic [31:0] adr, input logic we,
                     input logic [31:0] dat, input logic [3:0] sel,
                     input logic exp_err, input logic chk, input logic [31:0] exp_dat);
    exp_t e;
    int   lat;
    e.err = exp_err;
    e.chk = chk;
    e.dat = exp_dat;
    e.name = name;
    sb_q.push_back(e);
    adr_i = adr;
    we_i  = we;
    dat_i = dat;
    sel_i = sel;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!(ack_o || err_o) && lat < 10);
    check({name, " response edges"}, lat, 1);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    we_i  = 1'b0;
    @(posedge clk);
    #1;
    check({name, " ack/err one cycle"}, {30'b0, ack_o, err_o}, 32'd0);
  endtask

  task automatic rd(input string name, input logic [31:0] adr, input logic [31:0] exp_dat);
    bus(name, adr, 1'b0, 32'd0, 4'h1, 1'b0, 1'b1, exp_dat);
  endtask

  task automatic wr(input string name, input logic [31:0] adr, input logic [31:0] dat,
                    input logic [3:0] sel);
    bus(name, adr, 1'b1, dat, sel, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every ack/err must match the oldest expected response.
  always @(negedge clk) begin
    if (ack_o || err_o) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected response: ack=%0b err=%0b, required none", ack_o, err_o);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, " err flag"}, {31'b0, err_o}, {31'b0, mon_e.err});
        check({mon_e.name, " ack flag"}, {31'b0, ack_o}, {31'b0, ~mon_e.err});
        if (mon_e.chk) check({mon_e.name, " data"}, dat_o, mon_e.dat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    adr_i = '0;
    dat_i = '0;
    sel_i = '0;
    we_i  = 1'b0;
    cyc_i = 1'b0;
    stb_i = 1'b0;
    btn   = '0;
    idle(3);
    rst = 1'b0;

    check("reset ack", {31'b0, ack_o}, 32'd0);
    check("reset err", {31'b0, err_o}, 32'd0);
    check("reset dat", dat_o, 32'd0);
    check("reset led", {29'b0, led}, 32'd0);
    check("reset int", {31'b0, irq}, 32'd0);

    rd("rd BTN reset", 32'h00, 32'h0);
    rd("rd LED reset", 32'h04, 32'h0);
    rd("rd EN reset", 32'h08, 32'h0);
    rd("rd PEND reset", 32'h0C, 32'h0);
    rd("rd RAW reset", 32'h10, 32'h0);

    // LED write with and without sel[0].
    wr("wr LED 5", 32'h04, 32'h5, 4'h1);
    check("led after wr 5", {29'b0, led}, 32'h5);
    rd("rd LED 5", 32'h04, 32'h5);
    wr("wr LED 7 sel0", 32'h04, 32'h7, 4'h0);
    check("led after sel0 wr", {29'b0, led}, 32'h5);
    rd("rd LED still 5", 32'h04, 32'h5);
    wr("wr BTN ignored", 32'h00, 32'hFF, 4'h1);

    // btn2 press: RAW after 2 edges, BTN after 6 edges, pend set with IRQ disabled.
    btn[2] = 1'b1;
    rd("rd RAW edge1", 32'h10, 32'h0);
    rd("rd RAW edge3", 32'h10, 32'h4);
    rd("rd BTN edge5", 32'h00, 32'h0);
    rd("rd BTN edge7", 32'h00, 32'h4);
    rd("rd PEND btn2", 32'h0C, 32'h4);
    check("int with en=0", {31'b0, irq}, 32'd0);
    wr("wr EN 4", 32'h08, 32'h4, 4'h1);
    check("int after enable", {31'b0, irq}, 32'd1);
    wr("w1c PEND 4", 32'h0C, 32'h4, 4'h1);
    check("int after w1c bit2", {31'b0, irq}, 32'd0);

    // Three-cycle glitch on btn1 must be rejected.
    btn[1] = 1'b1;
    idle(3);
    btn[1] = 1'b0;
    idle(10);
    rd("rd BTN after glitch", 32'h00, 32'h4);
    rd("rd PEND after glitch", 32'h0C, 32'h0);
    check("int after glitch", {31'b0, irq}, 32'd0);

    // btn0 press with enable, then release (falling edge sets nothing).
    wr("wr EN 1", 32'h08, 32'h1, 4'h1);
    btn[0] = 1'b1;
    idle(10);
    check("int after btn0 rise", {31'b0, irq}, 32'd1);
    rd("rd PEND btn0", 32'h0C, 32'h1);
    btn[0] = 1'b0;
    idle(10);
    rd("rd BTN btn0 released", 32'h00, 32'h4);
    rd("rd PEND after fall", 32'h0C, 32'h1);

    // New btn0 rise lands on the W1C ack edge: rise wins.
    btn[0] = 1'b1;
    idle(5);
    wr("w1c PEND 1 vs rise", 32'h0C, 32'h1, 4'h1);
    check("int after w1c vs rise", {31'b0, irq}, 32'd1);
    rd("rd PEND rise wins", 32'h0C, 32'h1);
    wr("w1c PEND 1 alone", 32'h0C, 32'h1, 4'h1);
    check("int after w1c alone", {31'b0, irq}, 32'd0);
    rd("rd PEND cleared", 32'h0C, 32'h0);

    // Unmapped access errors without side effects.
    bus("rd 0x18 unmapped", 32'h18, 1'b0, 32'h0, 4'h1, 1'b1, 1'b1, 32'h0);
    bus("wr 0x14 unmapped", 32'h14, 1'b1, 32'hFF, 4'h1, 1'b1, 1'b1, 32'h0);
    check("led after unmapped", {29'b0, led}, 32'h5);
    rd("rd EN after unmapped", 32'h08, 32'h1);

    // Reset while a request is pending: discarded, everything cleared.
    btn   = '0;
    adr_i = 32'h04;
    we_i  = 1'b0;
    sel_i = 4'h1;
    cyc_i = 1'b1;
    stb_i = 1'b1;
    rst   = 1'b1;
    idle(1);
    check("mid-reset ack", {31'b0, ack_o}, 32'd0);
    check("mid-reset err", {31'b0, err_o}, 32'd0);
    check("mid-reset dat", dat_o, 32'd0);
    cyc_i = 1'b0;
    stb_i = 1'b0;
    idle(1);
    rst = 1'b0;
    check("post-reset led", {29'b0, led}, 32'd0);
    check("post-reset int", {31'b0, irq}, 32'd0);
    rd("rd LED post-reset", 32'h04, 32'h0);
    rd("rd EN post-reset", 32'h08, 32'h0);
    rd("rd PEND post-reset", 32'h0C, 32'h0);
    rd("rd BTN post-reset", 32'h00, 32'h0);
    rd("rd RAW post-reset", 32'h10, 32'h0);

    idle(2);
    check("scoreboard drained", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
